chain_latency_probe: RTL and testbench
======================================

// Module: chain_latency_probe
// PURPOSE
//   Upstream driver / downstream monitor for one delay-chain lane. Owns the chain's data input,
//   waits until the chain is flushed, then launches a single transition. Counts clk edges until
//   that transition appears at the chain output. Reports latency, or a timeout if the transition
//   never arrives. One instance per lane, placed between the top-level pins and the testchain.
// PARAMETERS
//   CNT_W    10    width of the latency counter and the latency output
//   SETTLE   4     consecutive cycles with chain_dout==chain_din needed before launch (>=1)
//   TIMEOUT  1000  max cycles in SETTLE or MEASURE before giving up (1..2^CNT_W-2)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous reset, active-high
//   start      in   1      request a measurement; sampled only in IDLE
//   chain_dout in   1      output of the delay chain (synchronous to clk)
//   chain_din  out  1      registered drive to the delay chain input
//   busy       out  1      high in SETTLE, LAUNCH, MEASURE
//   done       out  1      one-cycle pulse when a result (latency or timeout) is posted
//   timeout    out  1      high when the last measurement timed out; held until next accepted start
//   latency    out  CNT_W  last measured latency; held until next result
// BEHAVIOUR
//   Reset (rst=1 at an edge, from any state): state=IDLE, chain_din=0, busy=0, done=0,
//     timeout=0, latency=0, all counters=0. A mid-measurement reset aborts with no done pulse.
//   IDLE: chain_din is held. start=1 -> SETTLE, with settle_cnt=0 and tmo_cnt=0. Clear timeout
//     at the same edge. latency keeps its old value.
//   SETTLE: each edge does tmo_cnt++.
//     - chain_dout==chain_din: settle_cnt++.
//     - Mismatch: settle_cnt=0.
//     - settle_cnt reaches SETTLE -> LAUNCH.
//     - tmo_cnt reaches TIMEOUT first -> post a timeout result.
//   LAUNCH (1 cycle): chain_din <= ~chain_din, cnt=0 -> MEASURE.
//   MEASURE: at each edge, compare the pre-edge chain_dout with chain_din.
//     - Equal: latency<=cnt, done=1 -> IDLE.
//     - Not equal: cnt++.
//     - cnt reaches TIMEOUT with no match: post a timeout result.
//   Posting a timeout result: latency <= all-ones, timeout=1, done=1 -> IDLE.
//   Latency definition: N register stages between chain_din and chain_dout gives latency=N.
//     Direct wire loopback gives 0. One flop gives 1.
//   chain_din polarity alternates on every launch. It is never reset except by rst.
//   A timed-out launch keeps its toggled chain_din; the next SETTLE re-flushes the chain.
//   start is ignored while busy; start held high re-triggers once per return to IDLE.
//   done is asserted only in the cycle after the result edge, never together with busy.
//   Counters saturate, never wrap: TIMEOUT < 2^CNT_W-1 keeps the all-ones code unambiguous.
// TESTING
//   1. Ideal 128-flop shift-register model, CNT_W=10, start pulse after reset
//      -> SETTLE completes, chain_din 0->1, done pulse with latency=128, timeout=0.
//   2. Second start on the same chain -> chain_din 1->0, latency=128 again.
//   3. Wire loopback (chain_dout=chain_din) -> latency=0.
//      One-flop loopback -> latency=1.
//   4. chain_dout tied 0 after first launch, TIMEOUT=200
//      -> done after exactly 200 MEASURE cycles, latency=10'h3FF, timeout=1.
//   5. chain_dout toggling every cycle during SETTLE
//      -> no launch; timeout result after TIMEOUT cycles; chain_din unchanged.
//   6. rst asserted in MEASURE cycle 50 -> next edge: IDLE, chain_din=0, latency=0, no done;
//      start ignored while busy (pulse in MEASURE has no effect).

Source files
------------

// File: rtl/chain_latency_probe.sv
`default_nettype none
// ============================================================================
// Module  : chain_latency_probe
// Brief   : Drives one delay-chain lane, launches a single transition once the
//           chain is flushed, and reports the edge count until it returns.
// Revision: 1.0 - initial release
// ============================================================================
module chain_latency_probe #(
    parameter int CNT_W   = 10,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             chain_dout,
    output logic             chain_din,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] latency
);

    localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ALL_ONES  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_LAUNCH  = 2'd2,
        ST_MEASURE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             chain_din_q, chain_din_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] latency_q, latency_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             match;
    logic [CNT_W-1:0] settle_inc;
    logic [CNT_W-1:0] tmo_inc;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increments: counters park at all-ones instead of wrapping.
    assign match      = (chain_dout == chain_din_q);
    assign settle_inc = (settle_cnt_q == ALL_ONES) ? settle_cnt_q : settle_cnt_q + ONE_C;
    assign tmo_inc    = (tmo_cnt_q == ALL_ONES) ? tmo_cnt_q : tmo_cnt_q + ONE_C;
    assign cnt_inc    = (cnt_q == ALL_ONES) ? cnt_q : cnt_q + ONE_C;

    always_comb begin
        state_d      = state_q;
        chain_din_d  = chain_din_q;
        done_d       = 1'b0;
        timeout_d    = timeout_q;
        latency_d    = latency_q;
        settle_cnt_d = settle_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                    tmo_cnt_d    = '0;
                    timeout_d    = 1'b0;
                end
            end
            ST_SETTLE: begin
                tmo_cnt_d    = tmo_inc;
                settle_cnt_d = match ? settle_inc : '0;
                // A flushed chain wins over a timeout landing on the same edge.
                if (match && settle_inc == SETTLE_C) begin
                    state_d = ST_LAUNCH;
                end else if (tmo_inc == TIMEOUT_C) begin
                    latency_d = ALL_ONES;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                chain_din_d = ~chain_din_q;
                cnt_d       = '0;
                state_d     = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (match) begin
                    latency_d = cnt_q;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) begin
                        latency_d = ALL_ONES;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            chain_din_q  <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            latency_q    <= '0;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            chain_din_q  <= chain_din_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            latency_q    <= latency_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            cnt_q        <= cnt_d;
        end
    end

    assign chain_din = chain_din_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign latency   = latency_q;

endmodule
`default_nettype wire

// File: tb/tb_chain_latency_probe.sv
`default_nettype none
// ============================================================================
// Module  : tb_chain_latency_probe
// Brief   : Directed self-checking bench for chain_latency_probe using several
//           chain models (128-flop shift, wire, one flop, stuck-0, toggling).
// Revision: 1.0 - initial release
// ============================================================================
module tb_chain_latency_probe;

    localparam int CNT_W   = 10;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 200;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             chain_dout;
    logic             chain_din;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] latency;

    int vectors = 0;
    int errors  = 0;

    // 0: 128-flop chain, 1: wire, 2: one flop, 3: stuck 0, 4: toggle
    int           mode = 0;
    logic [127:0] sr   = '0;
    logic         fl   = 1'b0;
    logic         tog  = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        sr  <= {sr[126:0], chain_din};
        fl  <= chain_din;
        tog <= ~tog;
    end

    always_comb begin
        chain_dout = 1'b0;
        case (mode)
            0: chain_dout = sr[127];
            1: chain_dout = chain_din;
            2: chain_dout = fl;
            3: chain_dout = 1'b0;
            4: chain_dout = tog;
            default: chain_dout = 1'b0;
        endcase
    end

    chain_latency_probe #(
        .CNT_W  (CNT_W),
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .chain_dout(chain_dout),
        .chain_din (chain_din),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .latency   (latency)
    );

    // Pulses start for one edge, then returns the number of edges after the
    // accepting edge at which done is first seen (-1 if the budget expires).
    task automatic run_measure(input int budget, output int edges);
        edges = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++; if (timeout !== 1'b0)   begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        vectors++; if (latency !== 10'd0)  begin errors++; $display("FAIL reset_latency got=%0d exp=0", latency); end
        vectors++; if (chain_din !== 1'b0) begin errors++; $display("FAIL reset_din got=%b exp=0", chain_din); end
    endtask

    task automatic test_chain_128();
        int e;
        logic exp_din;
        mode = 0;
        for (int k = 0; k < 2; k++) begin
            exp_din = (k == 0) ? 1'b1 : 1'b0;
            run_measure(400, e);
            vectors++; if (e != 134)           begin errors++; $display("FAIL chain128_edges[%0d] got=%0d exp=134", k, e); end
            vectors++; if (latency !== 10'd128) begin errors++; $display("FAIL chain128_latency[%0d] got=%0d exp=128", k, latency); end
            vectors++; if (timeout !== 1'b0)   begin errors++; $display("FAIL chain128_timeout[%0d] got=%b exp=0", k, timeout); end
            vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL chain128_busy_at_done[%0d] got=%b exp=0", k, busy); end
            vectors++; if (chain_din !== exp_din) begin errors++; $display("FAIL chain128_din[%0d] got=%b exp=%b", k, chain_din, exp_din); end
            @(posedge clk); #1;
            vectors++; if (done !== 1'b0)      begin errors++; $display("FAIL chain128_done_pulse[%0d] got=%b exp=0", k, done); end
        end
    endtask

    task automatic test_loopback();
        int e;
        mode = 1;
        run_measure(50, e);
        vectors++; if (e != 6)              begin errors++; $display("FAIL wire_edges got=%0d exp=6", e); end
        vectors++; if (latency !== 10'd0)   begin errors++; $display("FAIL wire_latency got=%0d exp=0", latency); end
        vectors++; if (chain_din !== 1'b1)  begin errors++; $display("FAIL wire_din got=%b exp=1", chain_din); end
        repeat (3) @(posedge clk);
        #1;
        mode = 2;
        run_measure(50, e);
        vectors++; if (e != 7)              begin errors++; $display("FAIL flop_edges got=%0d exp=7", e); end
        vectors++; if (latency !== 10'd1)   begin errors++; $display("FAIL flop_latency got=%0d exp=1", latency); end
        vectors++; if (chain_din !== 1'b0)  begin errors++; $display("FAIL flop_din got=%b exp=0", chain_din); end
    endtask

    task automatic test_back_to_back();
        int e1;
        int e2;
        mode  = 1;
        e1    = -1;
        e2    = -1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (done) begin e1 = i; break; end
        end
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (done) begin e2 = i; break; end
        end
        start = 1'b0;
        vectors++; if (e1 != 6)             begin errors++; $display("FAIL b2b_first_edges got=%0d exp=6", e1); end
        vectors++; if (e2 != 7)             begin errors++; $display("FAIL b2b_retrigger_edges got=%0d exp=7", e2); end
        vectors++; if (chain_din !== 1'b0)  begin errors++; $display("FAIL b2b_din got=%b exp=0", chain_din); end
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL b2b_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_timeout_measure();
        int e;
        mode = 3;
        run_measure(400, e);
        vectors++; if (e != 205)              begin errors++; $display("FAIL tmo_meas_edges got=%0d exp=205", e); end
        vectors++; if (latency !== 10'h3FF)   begin errors++; $display("FAIL tmo_meas_latency got=%h exp=3ff", latency); end
        vectors++; if (timeout !== 1'b1)      begin errors++; $display("FAIL tmo_meas_flag got=%b exp=1", timeout); end
        vectors++; if (chain_din !== 1'b1)    begin errors++; $display("FAIL tmo_meas_din got=%b exp=1", chain_din); end
    endtask

    task automatic test_timeout_settle();
        int e;
        mode = 4;
        run_measure(400, e);
        vectors++; if (e != 200)              begin errors++; $display("FAIL tmo_settle_edges got=%0d exp=200", e); end
        vectors++; if (latency !== 10'h3FF)   begin errors++; $display("FAIL tmo_settle_latency got=%h exp=3ff", latency); end
        vectors++; if (timeout !== 1'b1)      begin errors++; $display("FAIL tmo_settle_flag got=%b exp=1", timeout); end
        vectors++; if (chain_din !== 1'b1)    begin errors++; $display("FAIL tmo_settle_din got=%b exp=1", chain_din); end
        @(posedge clk); #1;
        vectors++; if (timeout !== 1'b1)      begin errors++; $display("FAIL tmo_flag_held got=%b exp=1", timeout); end
    endtask

    task automatic test_reset_mid_measure();
        int done_seen;
        mode  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (timeout !== 1'b0)   begin errors++; $display("FAIL mid_timeout_cleared got=%b exp=0", timeout); end
        vectors++; if (busy !== 1'b1)      begin errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (chain_din !== 1'b0) begin errors++; $display("FAIL mid_launched_din got=%b exp=0", chain_din); end
        repeat (45) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (busy !== 1'b1 || chain_din !== 1'b0) begin
            errors++; $display("FAIL mid_start_ignored got busy=%b din=%b exp busy=1 din=0", busy, chain_din);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        vectors++; if (chain_din !== 1'b0) begin errors++; $display("FAIL mid_rst_din got=%b exp=0", chain_din); end
        vectors++; if (latency !== 10'd0)  begin errors++; $display("FAIL mid_rst_latency got=%0d exp=0", latency); end
        vectors++; if (timeout !== 1'b0)   begin errors++; $display("FAIL mid_rst_timeout got=%b exp=0", timeout); end
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        vectors++; if (done_seen != 0)     begin errors++; $display("FAIL mid_rst_no_done got=%0d exp=0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_chain_128();
        test_loopback();
        test_back_to_back();
        test_timeout_measure();
        test_timeout_settle();
        test_reset_mid_measure();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
